// File: rtl/tx_fifo_drain_if.sv
// tx_fifo_drain_if - FIFO read port and DSP sample port of the TX drain.
//
//   fifo_data       FIFO head word (first-word-fall-through)
//   fifo_src_rdy_i  FIFO not empty
//   fifo_dst_rdy_o  pop strobe back to the FIFO (combinational)
//   strobe          DSP sample request
//   sample          registered sample to the DSP
//   sample_valid    one-cycle pulse, sample was updated
//
// master: the drain block. slave: the FIFO/DSP environment.
interface tx_fifo_drain_if #(
    parameter int WIDTH = 36
);
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_src_rdy_i;
    logic             fifo_dst_rdy_o;
    logic             strobe;
    logic [31:0]      sample;
    logic             sample_valid;

    modport master (
        input  fifo_data, fifo_src_rdy_i, strobe,
        output fifo_dst_rdy_o, sample, sample_valid
    );

    modport slave (
        output fifo_data, fifo_src_rdy_i, strobe,
        input  fifo_dst_rdy_o, sample, sample_valid
    );
endinterface

// File: rtl/tx_fifo_drain.sv
// tx_fifo_drain - DAC-domain consumer of the external-SRAM TX FIFO.
//
// Pops FIFO lines only on DSP strobes, primes the FIFO before each burst
// (prime_len consecutive non-empty cycles), and flags/counts underruns.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          run request (level)
//   prime_len       consecutive non-empty cycles required before streaming
//   clear_stats     synchronous clear of underrun_count (wins over increment)
//   bus             FIFO read port + DSP sample port (tx_fifo_drain_if.master)
//   underrun        one-cycle pulse per underrun
//   underrun_count  saturating 16-bit underrun counter
//   state           00 IDLE, 01 PRIME, 10 RUN
//
// Build option: TX_DRAIN_UNDERRUN_HOLD_EN - when defined, sample keeps its
// last value on underrun instead of being forced to zero.
module tx_fifo_drain #(
    parameter int WIDTH      = 36,
    parameter int PRIME_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRIME_BITS-1:0] prime_len,
    input  logic                  clear_stats,
    tx_fifo_drain_if.master       bus,
    output logic                  underrun,
    output logic [15:0]           underrun_count,
    output logic [1:0]            state
);
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_PRIME = 2'b01;
    localparam logic [1:0] S_RUN   = 2'b10;

    logic [1:0]            r_state;
    logic [1:0]            w_nxt_state;
    logic [PRIME_BITS-1:0] r_prime_cnt;
    logic [31:0]           r_sample;
    logic                  r_sample_valid;
    logic                  r_underrun;
    logic [15:0]           r_underrun_count;
    logic                  w_pop;
    logic                  w_urun;
    logic                  w_eof;

    // SOF and the two spare bits carry no meaning here.
    logic w_unused_bits;
    assign w_unused_bits = ^{bus.fifo_data[WIDTH-1:34], bus.fifo_data[32]};

    assign w_eof = bus.fifo_data[33];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt_state;
    end

    // Next-state logic; dropping enable wins over everything.
    always_comb begin
        w_nxt_state = r_state;
        if (!enable) begin
            w_nxt_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_nxt_state = S_PRIME;
                S_PRIME: if (r_prime_cnt == prime_len) w_nxt_state = S_RUN;
                S_RUN:   if ((w_pop && w_eof) || w_urun) w_nxt_state = S_PRIME;
                default: w_nxt_state = S_IDLE;
            endcase
        end
    end

    // Output decode: pop and underrun only in RUN with enable held, so an
    // enable drop masks a coincident strobe in the same cycle.
    always_comb begin
        w_pop  = 1'b0;
        w_urun = 1'b0;
        if (r_state == S_RUN && enable && bus.strobe) begin
            w_pop  = bus.fifo_src_rdy_i;
            w_urun = ~bus.fifo_src_rdy_i;
        end
    end

    assign bus.fifo_dst_rdy_o = w_pop;

    // Prime counter: held at zero outside PRIME, so every PRIME entry starts
    // from zero; any empty cycle restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_prime_cnt <= '0;
        else if (r_state != S_PRIME) r_prime_cnt <= '0;
        else if (bus.fifo_src_rdy_i) r_prime_cnt <= r_prime_cnt + 1'b1;
        else                       r_prime_cnt <= '0;
    end

    // Sample path and underrun statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample         <= '0;
            r_sample_valid   <= 1'b0;
            r_underrun       <= 1'b0;
            r_underrun_count <= '0;
        end else begin
            r_sample_valid <= w_pop | w_urun;
            r_underrun     <= w_urun;
            if (w_pop) begin
                r_sample <= bus.fifo_data[31:0];
            end else if (w_urun) begin
`ifdef TX_DRAIN_UNDERRUN_HOLD_EN
                r_sample <= r_sample;
`else
                r_sample <= '0;
`endif
            end
            if (clear_stats)
                r_underrun_count <= '0;
            else if (w_urun && r_underrun_count != 16'hFFFF)
                r_underrun_count <= r_underrun_count + 16'd1;
        end
    end

    assign bus.sample       = r_sample;
    assign bus.sample_valid = r_sample_valid;
    assign underrun         = r_underrun;
    assign underrun_count   = r_underrun_count;
    assign state            = r_state;
endmodule

// File: tb/tb_tx_fifo_drain.sv
module tb_tx_fifo_drain;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  prime_len;
    logic        clear_stats;
    logic        underrun;
    logic [15:0] underrun_count;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entries: {underrun flag, sample}
    logic [32:0] exp_q[$];
    logic [31:0] last_sample = 32'h0;

    tx_fifo_drain_if #(.WIDTH(36)) bus ();

    tx_fifo_drain #(.WIDTH(36), .PRIME_BITS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .prime_len      (prime_len),
        .clear_stats    (clear_stats),
        .bus            (bus),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .state          (state)
    );

    always #5 clk = ~clk;

    // Output monitor: every sample_valid must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && bus.sample_valid) begin
            logic [32:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL monitor_unexpected: sample=%h underrun=%b with nothing expected",
                         bus.sample, underrun);
            end else begin
                e = exp_q.pop_front();
                if ({underrun, bus.sample} !== e) begin
                    n_fail++;
                    $display("FAIL monitor_sample: got urun=%b sample=%h required urun=%b sample=%h",
                             underrun, bus.sample, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pop(input logic [31:0] d);
        exp_q.push_back({1'b0, d});
        last_sample = d;
    endtask

    task automatic push_urun();
`ifdef TX_DRAIN_UNDERRUN_HOLD_EN
        exp_q.push_back({1'b1, last_sample});
`else
        exp_q.push_back({1'b1, 32'h0});
        last_sample = 32'h0;
`endif
    endtask

    task automatic go_run(input logic [7:0] plen);
        prime_len          = plen;
        enable             = 1'b1;
        bus.strobe         = 1'b0;
        bus.fifo_src_rdy_i = 1'b1;
        for (int i = 0; i < 300 && state !== 2'b10; i++) tick();
        n_checks++;
        if (state !== 2'b10) begin
            n_fail++;
            $display("FAIL go_run: state=%b required 10", state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; prime_len = 8'd0; clear_stats = 1'b0;
        bus.strobe = 1'b0; bus.fifo_src_rdy_i = 1'b1; bus.fifo_data = 36'h0;
        #12;
        n_checks++;
        if ({state, bus.sample, bus.sample_valid, underrun, underrun_count, bus.fifo_dst_rdy_o} !== 53'h0) begin
            n_fail++;
            $display("FAIL reset_state: state=%b sample=%h vld=%b urun=%b cnt=%h rdy=%b required all 0",
                     state, bus.sample, bus.sample_valid, underrun, underrun_count, bus.fifo_dst_rdy_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_priming();
        prime_len = 8'd4;
        bus.fifo_src_rdy_i = 1'b1;
        bus.fifo_data = {4'h0, 32'hDEAD0000};
        enable = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.strobe = 1'b1;
            #1;
            n_checks++;
            if (state !== 2'b01 || bus.fifo_dst_rdy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL prime_cycle%0d: state=%b rdy=%b required 01/0", i, state, bus.fifo_dst_rdy_o);
            end
            tick();
        end
        bus.strobe = 1'b0;
        n_checks++;
        if (state !== 2'b10) begin
            n_fail++;
            $display("FAIL prime_to_run: state=%b required 10", state);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] words [2];
        words[0] = 32'h00010002;
        words[1] = 32'h00030004;
        for (int i = 0; i < 2; i++) begin
            bus.fifo_data = {4'h0, words[i]};
            bus.fifo_src_rdy_i = 1'b1;
            bus.strobe = 1'b1;
            push_pop(words[i]);
            #1;
            n_checks++;
            if (bus.fifo_dst_rdy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_pop%0d: rdy=%b required 1", i, bus.fifo_dst_rdy_o);
            end
            tick();
            n_checks++;
            if (bus.sample !== words[i] || bus.sample_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_sample%0d: sample=%h vld=%b required %h/1",
                         i, bus.sample, bus.sample_valid, words[i]);
            end
        end
        bus.strobe = 1'b0;
    endtask

    task automatic test_underrun();
        logic [31:0] exp_s;
`ifdef TX_DRAIN_UNDERRUN_HOLD_EN
        exp_s = 32'h00030004;
`else
        exp_s = 32'h0;
`endif
        bus.fifo_src_rdy_i = 1'b0;
        bus.strobe = 1'b1;
        push_urun();
        tick();
        bus.strobe = 1'b0;
        n_checks++;
        if (underrun !== 1'b1 || underrun_count !== 16'd1 || state !== 2'b01 || bus.sample !== exp_s) begin
            n_fail++;
            $display("FAIL underrun: urun=%b cnt=%h state=%b sample=%h required 1/0001/01/%h",
                     underrun, underrun_count, state, bus.sample, exp_s);
        end
    endtask

    task automatic test_eof();
        go_run(8'd0);
        bus.fifo_data = {2'b00, 1'b1, 1'b1, 32'hCAFE0001};
        bus.strobe = 1'b1;
        push_pop(32'hCAFE0001);
        tick();
        bus.strobe = 1'b0;
        n_checks++;
        if (state !== 2'b01 || underrun_count !== 16'd1 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL eof: state=%b cnt=%h urun=%b required 01/0001/0", state, underrun_count, underrun);
        end
        prime_len = 8'd4;
        bus.fifo_data = {4'h0, 32'h11112222};
        bus.strobe = 1'b1;
        #1;
        n_checks++;
        if (bus.fifo_dst_rdy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL eof_no_pop: rdy=%b required 0", bus.fifo_dst_rdy_o);
        end
        tick();
        bus.strobe = 1'b0;
        n_checks++;
        if (bus.sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL eof_no_valid: vld=%b required 0", bus.sample_valid);
        end
    endtask

    task automatic test_saturation();
        force dut.r_underrun_count = 16'hFFFE;
        tick();
        release dut.r_underrun_count;
        for (int i = 0; i < 3; i++) begin
            go_run(8'd0);
            bus.fifo_src_rdy_i = 1'b0;
            bus.strobe = 1'b1;
            push_urun();
            tick();
            bus.strobe = 1'b0;
            n_checks++;
            if (underrun_count !== 16'hFFFF || underrun !== 1'b1) begin
                n_fail++;
                $display("FAIL saturate%0d: cnt=%h urun=%b required FFFF/1", i, underrun_count, underrun);
            end
        end
        go_run(8'd0);
        bus.fifo_src_rdy_i = 1'b0;
        bus.strobe = 1'b1;
        clear_stats = 1'b1;
        push_urun();
        tick();
        bus.strobe = 1'b0;
        clear_stats = 1'b0;
        n_checks++;
        if (underrun_count !== 16'h0 || underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_vs_urun: cnt=%h urun=%b required 0000/1", underrun_count, underrun);
        end
    endtask

    task automatic test_enable_drop();
        go_run(8'd2);
        bus.fifo_data = {4'h0, 32'h55556666};
        bus.fifo_src_rdy_i = 1'b1;
        bus.strobe = 1'b1;
        enable = 1'b0;
        #1;
        n_checks++;
        if (bus.fifo_dst_rdy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop_rdy: rdy=%b required 0", bus.fifo_dst_rdy_o);
        end
        tick();
        bus.strobe = 1'b0;
        n_checks++;
        if (state !== 2'b00 || bus.sample_valid !== 1'b0 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop_state: state=%b vld=%b urun=%b required 00/0/0",
                     state, bus.sample_valid, underrun);
        end
    endtask

    task automatic test_async_reset();
        go_run(8'd0);
        bus.fifo_src_rdy_i = 1'b0;
        bus.strobe = 1'b1;
        push_urun();
        tick();
        bus.strobe = 1'b0;
        go_run(8'd0);
        bus.fifo_data = {4'h0, 32'h12345678};
        bus.strobe = 1'b1;
        push_pop(32'h12345678);
        tick();
        bus.strobe = 1'b0;
        @(negedge clk);
        #1;
        bus.strobe = 1'b1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({state, bus.sample, bus.sample_valid, underrun, underrun_count, bus.fifo_dst_rdy_o} !== 53'h0) begin
            n_fail++;
            $display("FAIL async_reset: state=%b sample=%h vld=%b urun=%b cnt=%h rdy=%b required all 0",
                     state, bus.sample, bus.sample_valid, underrun, underrun_count, bus.fifo_dst_rdy_o);
        end
        bus.strobe = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_priming();
        test_streaming();
        test_underrun();
        test_eof();
        test_saturation();
        test_enable_drop();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_fifo_drain.md
# tx_fifo_drain

Output-side consumer of the external-SRAM TX FIFO, running in the DAC clock domain. Pops 36-bit lines from the FIFO's first-word-fall-through read port only when the TX DSP strobes for a sample, primes the buffer before each burst so that streaming does not start on a near-empty FIFO, and detects and counts underruns. Sits between the FIFO read port (dataout / src_rdy_o / dst_rdy_i) and the TX DSP sample input.

## Interface
- WIDTH, 36: FIFO line width. Bits 31:0 are the I/Q sample, bit 32 is SOF, bit 33 is EOF, and bits 35:34 are ignored.
- PRIME_BITS, 8: width of the prime-length field and of the prime counter.
- clk  in  1  DAC-domain clock.
- rst  in  1  Reset. Asynchronous and active-high.
- enable  in  1  Run request. Level-sensitive.
- prime_len  in  PRIME_BITS  Number of consecutive cycles the FIFO must show data before streaming starts. Quasi-static.
- clear_stats  in  1  Synchronous clear of underrun_count.
- fifo_data  in  WIDTH  FIFO head word (FWFT).
- fifo_src_rdy_i  in  1  FIFO not empty.
- fifo_dst_rdy_o  out  1  Pop strobe to the FIFO.
- strobe  in  1  DSP sample request. Single-cycle pulses, arbitrary spacing, may be back-to-back.
- sample  out  32  Registered sample to the DSP.
- sample_valid  out  1  One-cycle pulse: sample was updated.
- underrun  out  1  One-cycle pulse per underrun event.
- underrun_count  out  16  Saturating underrun counter.
- state  out  2  Current state: 00 IDLE, 01 PRIME, 10 RUN.

## Operation
- **IDLE**
  - fifo_dst_rdy_o=0.
  - sample is held.
  - enable=1 moves to PRIME and clears the prime counter.
- **PRIME**
  - The prime counter increments on each cycle with fifo_src_rdy_i=1 and resets to 0 on any cycle with fifo_src_rdy_i=0.
  - Moves to RUN on the cycle the counter equals prime_len. With prime_len=0, RUN is entered on the cycle after entering PRIME, regardless of fifo_src_rdy_i.
  - Strobes are ignored and nothing is popped: no sample_valid and no underrun.
- **RUN**
  - fifo_dst_rdy_o = enable & strobe & fifo_src_rdy_i. This is combinational; the FIFO requires the pop in the same cycle.
  - Pop: sample<=fifo_data[31:0] and sample_valid<=1. If fifo_data[33] (EOF) is set, move to PRIME with the counter cleared. This is a burst boundary and is not counted as an underrun.
  - strobe & ~fifo_src_rdy_i is an underrun:
    - sample<=0 (see Configuration) and sample_valid<=1.
    - underrun<=1 and underrun_count increments, saturating at 16'hFFFF.
    - Move to PRIME with the counter cleared.
  - No strobe: hold everything.
- **enable=0 in any state**
  - Moves to IDLE on the next edge.
  - fifo_dst_rdy_o is forced 0 combinationally in that same cycle, so a simultaneous strobe pops nothing and is not an underrun.
- **SOF bit:** carries no control meaning in this block and passes through ignored.
- **clear_stats:** clears underrun_count on the next edge. If it coincides with an underrun event, clear wins and the count becomes 0; the underrun pulse still fires.
- **Reset mid-burst:** aborts immediately. Any partially primed state is discarded.

## Timing
- All outputs reset to 0: fifo_dst_rdy_o, sample, sample_valid, underrun, underrun_count, state=IDLE. fifo_dst_rdy_o is combinational and is 0 whenever state≠RUN.
- Strobe to sample/sample_valid: 1 cycle.
- Underrun detection to the underrun pulse and count update: 1 cycle.
- Enable rise to PRIME: 1 cycle. PRIME to RUN: prime_len+1 cycles minimum, counted from PRIME entry with the FIFO continuously non-empty.
- Back-to-back strobes in RUN sustain one pop per cycle.

## Configuration
- **TX_DRAIN_UNDERRUN_HOLD_EN**
  - Defined: on underrun, sample keeps its previous value (last-sample hold); sample_valid still pulses.
  - Undefined (default): sample is forced to 32'h0 on underrun.
  - No other behaviour changes.

## Test plan
- **Priming:** prime_len=4, FIFO non-empty from cycle 0, enable rises. Required: state=01 for 5 cycles, then 10. No fifo_dst_rdy_o while in PRIME despite strobes.
- **Streaming:** in RUN, FIFO holds 32'h00010002, 32'h00030004; two back-to-back strobes. Required: two pops; sample=00010002 then 00030004 on consecutive cycles, one cycle after each strobe; sample_valid high both cycles.
- **Underrun:**
  - FIFO empty, strobe in RUN. Required: underrun=1, count 0→1, state→01.
  - Without TX_DRAIN_UNDERRUN_HOLD_EN, sample=0; with it, sample holds 00030004.
- **EOF:** pop a word with bit33=1. Required: state→01, underrun_count unchanged, next strobe before re-prime causes no pop.
- **Saturation and clear:** preload count to FFFE, cause 3 underruns. Required: count FFFF. Then pulse clear_stats coincident with a 4th underrun. Required: count=0 and underrun pulse still seen.
- **Enable drop / reset:** enable=0 on a strobe cycle in RUN. Required: fifo_dst_rdy_o=0, state→00. Async rst mid-RUN: all outputs 0 immediately.
